// File: rtl/conv_mdc_cfg_master_pkg.sv
// conv_mdc_package: shared constants and types for the conv_mdc control-port
// initiator.
//   - Register byte offsets on the conv_mdc peripheral control slave.
//   - cfg_master_state_t: job sequencer state encoding.
//   - job_reg_addr(): byte address of a job-dependent register.
package conv_mdc_package;

  localparam logic [31:0] CONV_MDC_OFFS_TRIGGER   = 32'h0000_0000;
  localparam logic [31:0] CONV_MDC_OFFS_ACQUIRE   = 32'h0000_0004;
  localparam logic [31:0] CONV_MDC_OFFS_SOFTCLEAR = 32'h0000_0014;
  localparam logic [31:0] CONV_MDC_OFFS_JOB_BASE  = 32'h0000_0040;

  typedef enum logic [3:0] {
    IDLE,
    ACQ,
    ACQ_RSP,
    BACKOFF,
    WR_PARAM,
    TRIGGER,
    WAIT_EVT,
    ABORT_DRAIN,
    SOFTCLR
  } cfg_master_state_t;

  // Job-dependent registers are 32-bit words packed from base upwards.
  function automatic logic [31:0] job_reg_addr(input logic [31:0] base,
                                               input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// hwpe_ctrl_intf_periph: request/grant peripheral control port.
//   master: drives req, add, wen, be, data, id; samples gnt, r_data, r_valid, r_id.
//   slave : the mirror image.
//   wen=1 is a read and wen=0 is a write.
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned ID_WIDTH = 10
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic [31:0]         r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );
endinterface

// File: rtl/conv_mdc_cfg_master_bus.sv
// conv_mdc_cfg_master_bus: single-transaction periph driver.
//   cmd_*_i     : new transaction. It is only presented when the port can take
//                 it, which means no req is pending, or the pending req is
//                 granted this cycle.
//   wr_ack_o    : pending write granted this cycle.
//   rd_gnt_o    : pending read granted this cycle.
//   rsp_valid_o : read data for the outstanding read is on rsp_data_o.
//   idle_o      : no request pending and no read response outstanding.
//   req_o..data_o, gnt_i, r_*_i : periph master signals.
module conv_mdc_cfg_master_bus #(
  parameter int unsigned ID_WIDTH = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                cmd_valid_i,
  input  logic                cmd_read_i,
  input  logic [31:0]         cmd_addr_i,
  input  logic [31:0]         cmd_wdata_i,
  output logic                wr_ack_o,
  output logic                rd_gnt_o,
  output logic                rsp_valid_o,
  output logic [31:0]         rsp_data_o,
  output logic                idle_o,
  output logic                req_o,
  output logic [31:0]         add_o,
  output logic                wen_o,
  output logic [3:0]          be_o,
  output logic [31:0]         data_o,
  input  logic                gnt_i,
  input  logic [31:0]         r_data_i,
  input  logic                r_valid_i,
  input  logic [ID_WIDTH-1:0] r_id_i
);

  logic        req_q, req_d;
  logic [31:0] add_q, add_d;
  logic        wen_q, wen_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] data_q, data_d;
  logic        rd_pend_q, rd_pend_d;

  logic granted;
  logic rsp_valid;

  assign granted = req_q & gnt_i;
  // Only responses tagged with the issued id (always 0) are taken.
  assign rsp_valid = rd_pend_q & r_valid_i & (r_id_i == '0);

  always_comb begin
    req_d     = req_q;
    add_d     = add_q;
    wen_d     = wen_q;
    be_d      = be_q;
    data_d    = data_q;
    rd_pend_d = rd_pend_q;
    if (granted) begin
      req_d = 1'b0;
      if (wen_q) rd_pend_d = 1'b1;
    end
    if (rsp_valid) rd_pend_d = 1'b0;
    // A new command in the grant cycle keeps req high: one transfer per cycle.
    if (cmd_valid_i) begin
      req_d  = 1'b1;
      add_d  = cmd_addr_i;
      wen_d  = cmd_read_i;
      be_d   = 4'hF;
      data_d = cmd_read_i ? 32'h0 : cmd_wdata_i;
    end
    if (clear_i) begin
      req_d     = 1'b0;
      add_d     = '0;
      wen_d     = 1'b1;
      be_d      = '0;
      data_d    = '0;
      rd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q     <= 1'b0;
      add_q     <= '0;
      wen_q     <= 1'b1;
      be_q      <= '0;
      data_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      add_q     <= add_d;
      wen_q     <= wen_d;
      be_q      <= be_d;
      data_q    <= data_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign wr_ack_o    = granted & ~wen_q;
  assign rd_gnt_o    = granted & wen_q;
  assign rsp_valid_o = rsp_valid;
  assign rsp_data_o  = r_data_i;
  assign idle_o      = ~req_q & ~rd_pend_q;
  assign req_o       = req_q;
  assign add_o       = add_q;
  assign wen_o       = wen_q;
  assign be_o        = be_q;
  assign data_o      = data_q;

endmodule

// File: rtl/conv_mdc_cfg_master.sv
// conv_mdc_cfg_master: job sequencer for the conv_mdc control port.
//   cfg_valid_i/cfg_idx_i/cfg_data_i : parameter table write (IDLE only).
//   cfg_ready_o                      : table writable (IDLE).
//   start_i                          : launch job. abort_i : abort job.
//   evt_i                            : end-of-job event from the accelerator.
//   busy_o                           : not IDLE.
//   done_o                           : one-cycle completion pulse.
//   job_id_o                         : id returned by the last successful acquire.
//   periph                           : periph master port.
// The sequence is: acquire (with retry backoff), N_PARAMS parameter writes,
// trigger, then wait for the event.
module conv_mdc_cfg_master
  import conv_mdc_package::*;
#(
  parameter int unsigned N_PARAMS      = 24,
  parameter int unsigned ID_WIDTH      = 10,
  parameter int unsigned ACQ_BACKOFF   = 8,
  parameter logic [31:0] REG_OFFS_BASE = CONV_MDC_OFFS_JOB_BASE
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [$clog2(N_PARAMS)-1:0] cfg_idx_i,
  input  logic [31:0]                 cfg_data_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic                        evt_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [7:0]                  job_id_o,
  hwpe_ctrl_intf_periph.master        periph
);

  localparam int unsigned IDX_W  = $clog2(N_PARAMS);
  localparam int unsigned CNT_W  = $clog2(N_PARAMS + 1);
  localparam int unsigned BOFF_W = $clog2(ACQ_BACKOFF + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N_PARAMS - 1);
  localparam logic [BOFF_W-1:0] BOFF_LAST = BOFF_W'(ACQ_BACKOFF - 1);

  cfg_master_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BOFF_W-1:0] boff_q, boff_d;
  logic [7:0]        job_id_q, job_id_d;
  logic              done_q, done_d;
  logic [31:0]       param_tab_q [N_PARAMS];
  logic [31:0]       param_tab_d [N_PARAMS];

  logic        cmd_valid, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        bus_wr_ack, bus_rd_gnt, bus_rsp_valid, bus_idle;
  logic [31:0] bus_rsp_data;
  logic        abort_take;
  logic        unused_rsp_bits;

  assign unused_rsp_bits = ^bus_rsp_data[31:9];

  // An event coinciding with abort in WAIT_EVT completes the job normally.
  assign abort_take = abort_i &&
                      ((state_q inside {ACQ, ACQ_RSP, BACKOFF, WR_PARAM, TRIGGER}) ||
                       (state_q == WAIT_EVT && !evt_i));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boff_d      = boff_q;
    job_id_d    = job_id_q;
    done_d      = 1'b0;
    param_tab_d = param_tab_q;
    cmd_valid   = 1'b0;
    cmd_read    = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    // Commands are issued on the transition edge so the bus keeps one
    // transfer per cycle when the slave grants back-to-back.
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i && (32'(cfg_idx_i) < N_PARAMS))
          param_tab_d[cfg_idx_i] = cfg_data_i;
        if (start_i) begin
          state_d   = ACQ;
          cmd_valid = 1'b1;
          cmd_read  = 1'b1;
          cmd_addr  = CONV_MDC_OFFS_ACQUIRE;
        end
      end
      ACQ: if (bus_rd_gnt) state_d = ACQ_RSP;
      ACQ_RSP: begin
        if (bus_rsp_valid) begin
          if (bus_rsp_data[8]) begin
            state_d = BACKOFF;
            boff_d  = '0;
          end else begin
            job_id_d  = bus_rsp_data[7:0];
            cnt_d     = '0;
            state_d   = WR_PARAM;
            cmd_valid = 1'b1;
            cmd_addr  = job_reg_addr(REG_OFFS_BASE, 32'h0);
            cmd_wdata = param_tab_q[0];
          end
        end
      end
      BACKOFF: begin
        if (boff_q == BOFF_LAST) begin
          state_d   = ACQ;
          cmd_valid = 1'b1;
          cmd_read  = 1'b1;
          cmd_addr  = CONV_MDC_OFFS_ACQUIRE;
        end else begin
          boff_d = boff_q + BOFF_W'(1);
        end
      end
      WR_PARAM: begin
        if (bus_wr_ack) begin
          cmd_valid = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d  = TRIGGER;
            cmd_addr = CONV_MDC_OFFS_TRIGGER;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            cmd_addr  = job_reg_addr(REG_OFFS_BASE, 32'(cnt_d));
            cmd_wdata = param_tab_q[cnt_d[IDX_W-1:0]];
          end
        end
      end
      TRIGGER: if (bus_wr_ack) state_d = WAIT_EVT;
      WAIT_EVT: begin
        if (evt_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ABORT_DRAIN: begin
        // Pending request or acquire response has to retire first.
        if (bus_idle) begin
          state_d   = SOFTCLR;
          cmd_valid = 1'b1;
          cmd_addr  = CONV_MDC_OFFS_SOFTCLEAR;
          cmd_wdata = 32'h1;
        end
      end
      SOFTCLR: if (bus_wr_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_take) begin
      state_d   = ABORT_DRAIN;
      cnt_d     = cnt_q;
      job_id_d  = job_id_q;
      cmd_valid = 1'b0;
    end

    if (clear_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      boff_d   = '0;
      job_id_d = '0;
      done_d   = 1'b0;
      for (int i = 0; i < N_PARAMS; i++) param_tab_d[i] = '0;
      cmd_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      boff_q   <= '0;
      job_id_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < N_PARAMS; i++) param_tab_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      boff_q      <= boff_d;
      job_id_q    <= job_id_d;
      done_q      <= done_d;
      param_tab_q <= param_tab_d;
    end
  end

  conv_mdc_cfg_master_bus #(
    .ID_WIDTH(ID_WIDTH)
  ) u_bus (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .cmd_valid_i (cmd_valid),
    .cmd_read_i  (cmd_read),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .wr_ack_o    (bus_wr_ack),
    .rd_gnt_o    (bus_rd_gnt),
    .rsp_valid_o (bus_rsp_valid),
    .rsp_data_o  (bus_rsp_data),
    .idle_o      (bus_idle),
    .req_o       (periph.req),
    .add_o       (periph.add),
    .wen_o       (periph.wen),
    .be_o        (periph.be),
    .data_o      (periph.data),
    .gnt_i       (periph.gnt),
    .r_data_i    (periph.r_data),
    .r_valid_i   (periph.r_valid),
    .r_id_i      (periph.r_id)
  );

  assign periph.id   = '0;
  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign job_id_o    = job_id_q;

endmodule

// File: tb/tb_conv_mdc_cfg_master.sv
// Bench for conv_mdc_cfg_master: random-stall periph slave, transaction log,
// and an expected transaction list derived from the parameter table contents.
module tb_conv_mdc_cfg_master;

  localparam int N = 24;

  typedef struct packed {
    logic        wen;
    logic [31:0] add;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [4:0]  cfg_idx = '0;
  logic [31:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        abort_s = 1'b0;
  logic        evt = 1'b0;
  logic        cfg_ready, busy, done;
  logic [7:0]  job_id;

  hwpe_ctrl_intf_periph #(.ID_WIDTH(10)) periph ();

  conv_mdc_cfg_master #(
    .N_PARAMS(N), .ID_WIDTH(10), .ACQ_BACKOFF(8), .REG_OFFS_BASE(32'h40)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx),
    .cfg_data_i(cfg_data), .start_i(start), .abort_i(abort_s), .evt_i(evt),
    .busy_o(busy), .done_o(done), .job_id_o(job_id), .periph(periph)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  logic [31:0] tab [N];
  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] acq_q[$];
  int          rsp_q[$];
  int          rise_q[$];
  int unsigned max_stall = 0;
  int          stall_left = 0;
  logic [31:0] hold_addr = '0;
  int          hold_cnt = 0;
  bit          bad_id_once = 0;
  bit          rd_sched = 0;
  bit          stalled_prev = 0;
  txn_t        held;
  bit          trig_seen = 0;
  int          trig_cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Periph slave: decides gnt at negedge for the following posedge, returns
  // read data one cycle after a read grant, and logs every granted transfer.
  always @(negedge clk) begin : slave
    bit g;
    periph.r_valid = 1'b0;
    periph.r_id    = '0;
    if (done) done_cnt++;
    if (!rst_n) begin
      periph.gnt = 1'b0; rd_sched = 0; stalled_prev = 0; stall_left = 0;
    end else begin
      if (rd_sched) begin
        periph.r_valid = 1'b1;
        if (bad_id_once) begin
          periph.r_id = 10'd5; periph.r_data = 32'h09; bad_id_once = 0;
        end else begin
          if (acq_q.size() > 0) periph.r_data = acq_q.pop_front();
          else periph.r_data = 32'h3;
          rsp_q.push_back(cyc + 1);
          rd_sched = 0;
        end
      end
      if (stalled_prev) begin
        check_eq("hold_req", periph.req, 1'b1);
        check_eq("hold_add", periph.add, held.add);
        check_eq("hold_data", periph.data, held.data);
        check_eq("hold_wen", periph.wen, held.wen);
      end
      if (periph.req && !stalled_prev && periph.wen && periph.add == 32'h4)
        rise_q.push_back(cyc);
      g = 0;
      if (periph.req) begin
        if (hold_cnt > 0 && periph.add == hold_addr) hold_cnt--;
        else if (stall_left > 0) stall_left--;
        else begin g = 1; stall_left = $urandom_range(0, max_stall); end
      end
      periph.gnt = g;
      if (g) begin
        log_q.push_back('{periph.wen, periph.add, periph.data});
        $display("txn %0d: %s add=0x%08h data=0x%08h", log_q.size(),
                 periph.wen ? "RD" : "WR", periph.add, periph.data);
        if (periph.wen) rd_sched = 1;
        else if (periph.add == 32'h0) begin trig_seen = 1; trig_cyc = cyc + 1; end
      end
      stalled_prev = periph.req && !g;
      held = '{periph.wen, periph.add, periph.data};
    end
  end

  task automatic clear_log();
    log_q.delete(); exp_q.delete(); rsp_q.delete(); rise_q.delete();
    acq_q.delete(); done_cnt = 0; trig_seen = 0;
  endtask

  task automatic program_table();
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      cfg_valid = 1; cfg_idx = 5'(i); cfg_data = tab[i];
    end
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic start_job(input bit with_cfg0, input logic [31:0] v0);
    @(posedge clk); #1;
    start = 1;
    if (with_cfg0) begin cfg_valid = 1; cfg_idx = 0; cfg_data = v0; tab[0] = v0; end
    @(posedge clk); #1;
    start = 0; cfg_valid = 0;
    start_cyc = cyc;
    check_eq("busy_run", busy, 1'b1);
    check_eq("cfg_ready_run", cfg_ready, 1'b0);
  endtask

  task automatic wait_trig(input int budget);
    int k = 0;
    while (!trig_seen && k < budget) begin @(posedge clk); k++; end
    check_eq("trigger_seen", trig_seen, 1'b1);
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin @(posedge clk); k++; end
    check_eq("log_reached", 32'(log_q.size() >= n), 1);
  endtask

  task automatic finish_job();
    @(posedge clk); #1; evt = 1;
    @(posedge clk); #1; evt = 0;
    check_eq("done_pulse", done, 1'b1);
    check_eq("busy_after_done", busy, 1'b0);
    @(posedge clk); #1;
    check_eq("done_single", done, 1'b0);
  endtask

  // Expected sequence: n_acq acquire reads, all parameter writes, trigger.
  task automatic build_exp(input int n_acq);
    exp_q.delete();
    for (int k = 0; k < n_acq; k++) exp_q.push_back('{1'b1, 32'h4, 32'h0});
    for (int i = 0; i < N; i++) exp_q.push_back('{1'b0, 32'h40 + 32'(4 * i), tab[i]});
    exp_q.push_back('{1'b0, 32'h0, 32'h0});
  endtask

  task automatic compare_log(input string tag);
    check_eq($sformatf("%s_count", tag), log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check_eq($sformatf("%s_wen%0d", tag, i), log_q[i].wen, exp_q[i].wen);
      check_eq($sformatf("%s_add%0d", tag, i), log_q[i].add, exp_q[i].add);
      if (!exp_q[i].wen)
        check_eq($sformatf("%s_data%0d", tag, i), log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req"}, periph.req, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_job_id"}, job_id, 8'h0);
    check_eq({tag, "_wen"}, periph.wen, 1'b1);
    check_eq({tag, "_add"}, periph.add, 32'h0);
    check_eq({tag, "_data"}, periph.data, 32'h0);
    check_eq({tag, "_be"}, periph.be, 4'h0);
    check_eq({tag, "_id"}, periph.id, 10'h0);
  endtask

  initial begin
    periph.gnt = 0; periph.r_valid = 0; periph.r_data = '0; periph.r_id = '0;
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1;

    // Job 1: table[i]=i*16+1, zero-wait slave, latency and completion.
    for (int i = 0; i < N; i++) tab[i] = 32'(i * 16 + 1);
    program_table();
    clear_log(); max_stall = 0; acq_q.push_back(32'h3);
    start_job(0, 0);
    wait_trig(200);
    check_eq("latency", trig_cyc - start_cyc, N + 3);
    repeat (50) @(posedge clk);
    #1 check_eq("no_early_done", done_cnt, 0);
    check_eq("busy_wait_evt", busy, 1'b1);
    finish_job();
    build_exp(1); compare_log("job1");
    check_eq("job1_id", job_id, 8'h03);
    check_eq("job1_done_cnt", done_cnt, 1);

    // Job 2: two busy acquires then success, check backoff spacing.
    clear_log();
    acq_q.push_back(32'h100); acq_q.push_back(32'h100); acq_q.push_back(32'h01);
    start_job(0, 0);
    wait_trig(400);
    finish_job();
    build_exp(3); compare_log("retry");
    check_eq("retry_id", job_id, 8'h01);
    check_eq("retry_reads", rise_q.size(), 3);
    for (int k = 1; k < rise_q.size() && k <= rsp_q.size(); k++)
      check_eq($sformatf("backoff_gap%0d", k), 32'(rise_q[k] - rsp_q[k-1] >= 8), 1);

    // Job 3: random table, random stalls, table write in the start cycle.
    for (int i = 0; i < N; i++) tab[i] = $urandom;
    program_table();
    clear_log(); max_stall = 5; acq_q.push_back(32'h05);
    start_job(1, $urandom);
    wait_trig(2000);
    finish_job();
    build_exp(1); compare_log("stall");
    check_eq("stall_id", job_id, 8'h05);

    // Job 4: abort while write 10 is stalled.
    max_stall = 0; stall_left = 0; clear_log(); acq_q.push_back(32'h02);
    hold_addr = 32'h40 + 32'd40; hold_cnt = 3;
    start_job(0, 0);
    begin
      int k = 0;
      while (!(periph.req && periph.add == hold_addr) && k < 200) begin @(negedge clk); k++; end
      check_eq("abort_point_seen", periph.add, hold_addr);
    end
    @(posedge clk); #1 abort_s = 1;
    @(posedge clk); #1 abort_s = 0;
    begin
      int k = 0;
      while (busy && k < 100) begin @(posedge clk); k++; end
      #1 check_eq("abort_idle", busy, 1'b0);
    end
    hold_cnt = 0;
    exp_q.delete();
    exp_q.push_back('{1'b1, 32'h4, 32'h0});
    for (int i = 0; i <= 10; i++) exp_q.push_back('{1'b0, 32'h40 + 32'(4 * i), tab[i]});
    exp_q.push_back('{1'b0, 32'h14, 32'h1});
    compare_log("abort");
    check_eq("abort_no_done", done_cnt, 0);

    // Job 5: abort and event in the same WAIT_EVT cycle.
    clear_log(); acq_q.push_back(32'h04);
    start_job(0, 0);
    wait_trig(200);
    repeat (3) @(posedge clk);
    #1 evt = 1; abort_s = 1;
    @(posedge clk); #1 evt = 0; abort_s = 0;
    check_eq("evt_wins_done", done, 1'b1);
    repeat (6) @(posedge clk);
    #1 build_exp(1); compare_log("evt_abort");
    check_eq("evt_abort_done_cnt", done_cnt, 1);

    // Job 6: first acquire response carries a foreign r_id.
    clear_log(); bad_id_once = 1; acq_q.push_back(32'h07);
    start_job(0, 0);
    wait_trig(200);
    finish_job();
    build_exp(1); compare_log("bad_rid");
    check_eq("bad_rid_id", job_id, 8'h07);

    // Job 7: async reset mid parameter writes, then the table must be zero.
    clear_log(); acq_q.push_back(32'h06);
    start_job(0, 0);
    wait_log(8, 200);
    @(posedge clk); #3 rst_n = 0;
    #1 check_idle_outputs("midrst");
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < N; i++) tab[i] = '0;
    clear_log(); acq_q.push_back(32'h08);
    start_job(0, 0);
    wait_trig(200);
    finish_job();
    build_exp(1); compare_log("post_rst");
    check_eq("post_rst_id", job_id, 8'h08);

    // Job 8: synchronous clear mid job, then the table must be zero.
    for (int i = 0; i < N; i++) tab[i] = $urandom;
    program_table();
    clear_log(); acq_q.push_back(32'h09);
    start_job(0, 0);
    wait_log(5, 200);
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
    check_idle_outputs("clear");
    for (int i = 0; i < N; i++) tab[i] = '0;
    @(posedge clk);
    clear_log(); acq_q.push_back(32'h0A);
    start_job(0, 0);
    wait_trig(200);
    finish_job();
    build_exp(1); compare_log("post_clr");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
